// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory port signals.
// The arbiter takes the slave view; the requesters/memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 8
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [31:0]   i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_func3;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [2:0]    m_func3;
    logic [31:0]   m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_func3, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, m_func3
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_func3, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, m_func3
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D) paths.
// D has fixed priority; a saturating counter forces an I grant after D_MAX D wins.
module mem_port_arbiter #(
    parameter int unsigned AW    = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned D_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [2:0] LatInit = 3'(LAT - 1);
    localparam logic [3:0] DMax    = 4'(D_MAX);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;  // 1 = D owns the access
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    func3_q, func3_d;
    logic [2:0]    lat_q, lat_d;
    logic [3:0]    starv_q, starv_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          grant_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        func3_d   = func3_q;
        lat_d     = lat_q;
        starv_d   = starv_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_d   = bus.d_req && !(bus.i_req && (starv_q == DMax));

        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StIssue;
                    owner_d = 1'b1;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    func3_d = bus.d_func3;
                    // D only wins against a waiting I while starv_q < D_MAX, so this saturates
                    if (bus.i_req) begin
                        starv_d = starv_q + 4'd1;
                    end
                end else if (bus.i_req) begin
                    state_d = StIssue;
                    owner_d = 1'b0;
                    addr_d  = bus.i_addr;
                    we_d    = 1'b0;
                    func3_d = 3'b010;
                    starv_d = 4'd0;
                end
            end
            StIssue: begin
                lat_d   = LatInit;
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == 3'd0) begin
                    state_d = StDone;
                    if (owner_q) begin
                        if (!we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end else begin
                        i_rdata_d = bus.m_rdata;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            func3_q   <= '0;
            lat_q     <= '0;
            starv_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            func3_q   <= func3_d;
            lat_q     <= lat_d;
            starv_q   <= starv_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign bus.m_en    = (state_q == StIssue);
    assign bus.m_we    = (state_q == StIssue) && we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.m_func3 = func3_q;
    assign bus.i_ack   = (state_q == StDone) && !owner_q;
    assign bus.d_ack   = (state_q == StDone) && owner_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule
